mem_access_sequencer: RTL
=========================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued commands (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before an access is abandoned.
REQ-003 SHALL have ports: clock  in  1  single clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: cmd_valid  in  1; cmd_ready  out  1; cmd_write  in  1 (1=write, 0=read); cmd_addr  in  6; cmd_data  in  16.
REQ-005 SHALL have ports: address  out  6; write_data  out  16; read  out  1; write  out  1 (hierarchy request side).
REQ-006 SHALL have ports: mem_done  in  1 (access-complete pulse); mem_read_data  in  16; mem_hit_L1  in  1; mem_hit_L2  in  1.
REQ-007 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  16; rsp_hit_L1  out  1; rsp_hit_L2  out  1; rsp_error  out  1.
REQ-008 SHALL have ports: cnt_hit_L1, cnt_hit_L2, cnt_miss  out  8 each; timeout_err  out  1 (sticky); busy  out  1.

Function
REQ-009 SHALL buffer commands in a FIFO_DEPTH-entry FIFO; push on cmd_valid && cmd_ready.
REQ-010 SHALL drive cmd_ready = (occupancy < FIFO_DEPTH), no same-cycle pop bypass; command offered while full stays pending on host side.
REQ-011 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one access outstanding at a time.
REQ-012 IDLE: FIFO non-empty -> ISSUE next cycle; else stay.
REQ-013 ISSUE: exactly one cycle; address/write_data from FIFO head; read=!cmd_write or write=cmd_write high for that cycle only; -> WAIT; wait counter cleared.
REQ-014 WAIT: address/write_data held stable, read/write low; on mem_done capture mem_read_data, mem_hit_L1, mem_hit_L2 into rsp_* -> RESP; mem_done in any other state ignored.
REQ-015 WAIT: counter increments each cycle without mem_done; counter == TIMEOUT -> rsp_error=1, rsp_data=16'h0000, hits=0, timeout_err set -> RESP; mem_done on that same cycle wins (no error).
REQ-016 RESP: rsp_valid high, rsp_* stable until rsp_ready; on handshake pop FIFO head, rsp_valid low next cycle, -> IDLE.
REQ-017 Write accesses SHALL return rsp_data = write data issued.
REQ-018 Counters update once per completed (non-timeout) access: mem_hit_L1 -> cnt_hit_L1 (priority if both set); else mem_hit_L2 -> cnt_hit_L2; else cnt_miss; each saturates at 255.
REQ-019 busy = (state != IDLE) || FIFO non-empty.
REQ-020 Wait counter width SHALL be clog2(TIMEOUT+1).

Reset
REQ-021 reset SHALL force IDLE, empty FIFO, counters 0, timeout_err 0, read/write/rsp_valid/rsp_error/rsp_hit_* 0, address 0, write_data 0, rsp_data 0, busy 0; cmd_ready 1 in first cycle after reset.
REQ-022 reset mid-access SHALL abandon the outstanding access without a response; a later mem_done SHALL be ignored in IDLE.

Structure
REQ-023 FSM state encoding and command record (write, addr[5:0], data[15:0], 23 bits) SHALL live in shared package mem_hier_pkg alongside address/data width constants (6, 16).
REQ-024 FIFO SHALL be a separate sub-module cmd_fifo (synchronous, reset-clear, full/empty/count outputs).

Verification
REQ-025 Read 6'h05 with mem_done 3 cycles after ISSUE, mem_read_data=16'hBEEF, mem_hit_L1=0, mem_hit_L2=0 -> rsp_data=16'hBEEF, cnt_miss=1, read high exactly 1 cycle.
REQ-026 Push 5 commands with FIFO_DEPTH=4 and mem_done held low -> cmd_ready=0 after 4th; 5th accepted only after first RESP handshake.
REQ-027 No mem_done for TIMEOUT=15 cycles -> rsp_error=1, rsp_data=0, timeout_err=1 sticky until reset; next command proceeds normally.
REQ-028 mem_hit_L1=1 and mem_hit_L2=1 together on completion -> cnt_hit_L1 +1, cnt_hit_L2 unchanged; 300 L1 hits -> cnt_hit_L1=255.
REQ-029 rsp_ready held low 10 cycles in RESP -> rsp_* stable, no new ISSUE; reset asserted in WAIT -> idle outputs next cycle, late mem_done produces no response.

Source files
------------

// File: rtl/mem_hier_pkg.sv
// Shared types for the memory access sequencer: bus widths, the FSM state
// encoding, the queued command record and a saturating counter helper.
package mem_hier_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // One queued command: 1 + 6 + 16 = 23 bits.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; reset empties it. The head entry stays visible on
// dout until it is popped, so the sequencer can keep using it across an access.
module cmd_fifo
  import mem_hier_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   din,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);
  localparam logic [PW:0] ZERO_C  = {(PW + 1){1'b0}};

  cmd_t          mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && (count_r != DEPTH_C);
  assign pop_ok_s  = pop && (count_r != ZERO_C);

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == ZERO_C);
  assign count = count_r;

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_C;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (PW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: queues host commands, issues them one at a time to
// the memory hierarchy, waits (with timeout) for completion, and returns one
// response per command while keeping hit/miss statistics.
module mem_access_sequencer
  import mem_hier_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              read,
  output logic              write,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_hit_L1,
  input  logic              mem_hit_L2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_hit_L1,
  output logic              rsp_hit_L2,
  output logic              rsp_error,
  output logic [7:0]        cnt_hit_L1,
  output logic [7:0]        cnt_hit_L2,
  output logic [7:0]        cnt_miss,
  output logic              timeout_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_r;
  state_t            state_s;
  cmd_t              cmd_in_s;
  cmd_t              head_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [FCW-1:0]    count_s;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic [ADDR_W-1:0] address_r;
  logic [DATA_W-1:0] write_data_r;
  logic              read_r;
  logic              write_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_hit_l1_r;
  logic              rsp_hit_l2_r;
  logic              rsp_error_r;
  logic [7:0]        cnt_hit_l1_r;
  logic [7:0]        cnt_hit_l2_r;
  logic [7:0]        cnt_miss_r;
  logic              timeout_err_r;

  assign cmd_in_s = '{write: cmd_write, addr: cmd_addr, data: cmd_data};
  assign push_s   = cmd_valid && cmd_ready;
  // The head is released only once its response has been accepted.
  assign pop_s    = (state_r == ST_RESP) && rsp_ready;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock(clock),
    .reset(reset),
    .push (push_s),
    .pop  (pop_s),
    .din  (cmd_in_s),
    .dout (head_s),
    .full (full_s),
    .empty(empty_s),
    .count(count_s)
  );

  assign cmd_ready   = !full_s;
  assign busy        = (state_r != ST_IDLE) || (count_s != {FCW{1'b0}});
  assign address     = address_r;
  assign write_data  = write_data_r;
  assign read        = read_r;
  assign write       = write_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_hit_L1  = rsp_hit_l1_r;
  assign rsp_hit_L2  = rsp_hit_l2_r;
  assign rsp_error   = rsp_error_r;
  assign cnt_hit_L1  = cnt_hit_l1_r;
  assign cnt_hit_L2  = cnt_hit_l2_r;
  assign cnt_miss    = cnt_miss_r;
  assign timeout_err = timeout_err_r;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; completion takes priority over timeout in WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (mem_done) begin
          state_s = ST_RESP;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Registered request, response and statistics outputs, aligned with the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r    <= {CNT_W{1'b0}};
      address_r     <= {ADDR_W{1'b0}};
      write_data_r  <= {DATA_W{1'b0}};
      read_r        <= 1'b0;
      write_r       <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= {DATA_W{1'b0}};
      rsp_hit_l1_r  <= 1'b0;
      rsp_hit_l2_r  <= 1'b0;
      rsp_error_r   <= 1'b0;
      cnt_hit_l1_r  <= 8'd0;
      cnt_hit_l2_r  <= 8'd0;
      cnt_miss_r    <= 8'd0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Load the request so read/write are high exactly during ISSUE.
          if (!empty_s) begin
            address_r    <= head_s.addr;
            write_data_r <= head_s.data;
            read_r       <= !head_s.write;
            write_r      <= head_s.write;
          end
        end
        ST_ISSUE: begin
          read_r     <= 1'b0;
          write_r    <= 1'b0;
          wait_cnt_r <= {CNT_W{1'b0}};
        end
        ST_WAIT: begin
          if (mem_done) begin
            rsp_valid_r  <= 1'b1;
            rsp_data_r   <= head_s.write ? write_data_r : mem_read_data;
            rsp_hit_l1_r <= mem_hit_L1;
            rsp_hit_l2_r <= mem_hit_L2;
            rsp_error_r  <= 1'b0;
            if (mem_hit_L1) begin
              cnt_hit_l1_r <= sat_inc8(cnt_hit_l1_r);
            end else if (mem_hit_L2) begin
              cnt_hit_l2_r <= sat_inc8(cnt_hit_l2_r);
            end else begin
              cnt_miss_r <= sat_inc8(cnt_miss_r);
            end
          end else if (wait_cnt_r == TIMEOUT_C) begin
            rsp_valid_r   <= 1'b1;
            rsp_data_r    <= {DATA_W{1'b0}};
            rsp_hit_l1_r  <= 1'b0;
            rsp_hit_l2_r  <= 1'b0;
            rsp_error_r   <= 1'b1;
            timeout_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          read_r  <= 1'b0;
          write_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
